decode_issue_stage: RTL and testbench

//  Parametrised decode/issue pipeline stage between fetch and execute.
//  - Holds one instruction (two with the skid option) in a registered slot.
//  - Resolves rs/rt operands through FWD_STAGES priority-ordered forwarding ports.
//  - Interlocks on producers whose result is not yet available, counts stall cycles, tags branch delay slots.
//  - Valid/ready on both sides, so upstream and downstream may stall independently.

---
 rtl/decode_issue_stage.sv | 218 +++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: holds the fetched instruction, resolves rs/rt through priority-ordered
// forwarding ports, interlocks on pending producers and tags branch delay slots.
// Optional 1-entry skid buffer behind the slot: define DECODE_ISSUE_SKID_EN.
module decode_issue_stage #(
    parameter int FWD_STAGES = 3,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             flush,

    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      in_pc,
    input  logic [31:0]                      in_instr,

    output logic [REG_ADDR_W-1:0]            rf_rs_addr,
    output logic [REG_ADDR_W-1:0]            rf_rt_addr,
    input  logic [DATA_W-1:0]                rf_rs_data,
    input  logic [DATA_W-1:0]                rf_rt_data,

    input  logic [FWD_STAGES-1:0]            fwd_valid,
    input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_rd,
    input  logic [FWD_STAGES-1:0]            fwd_data_ok,
    input  logic [FWD_STAGES*DATA_W-1:0]     fwd_data,

    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      out_pc,
    output logic [31:0]                      out_instr,
    output logic [DATA_W-1:0]                out_vs,
    output logic [DATA_W-1:0]                out_vt,
    output logic                             out_delay_slot,
    output logic [CNT_W-1:0]                 stall_count
);

    // Result of one operand lookup: {hazard, value}.
    function automatic logic [DATA_W:0] resolve(
        input logic [REG_ADDR_W-1:0]            addr,
        input logic [DATA_W-1:0]                rf_val,
        input logic [FWD_STAGES-1:0]            f_valid,
        input logic [FWD_STAGES*REG_ADDR_W-1:0] f_rd,
        input logic [FWD_STAGES-1:0]            f_ok,
        input logic [FWD_STAGES*DATA_W-1:0]     f_data
    );
        logic              hit;
        logic              haz;
        logic [DATA_W-1:0] val;
        hit = 1'b0;
        haz = 1'b0;
        val = rf_val;
        // Lowest index is the youngest producer, so the first match wins.
        for (int i = 0; i < FWD_STAGES; i++) begin
            if (!hit && f_valid[i] && (f_rd[i*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
                hit = 1'b1;
                if (f_ok[i]) begin
                    val = f_data[i*DATA_W +: DATA_W];
                end else begin
                    haz = 1'b1;
                end
            end
        end
        if (addr == '0) begin
            val = '0;
            haz = 1'b0;
        end
        return {haz, val};
    endfunction

    function automatic logic is_branch(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        return (op == 6'b000001) || (op == 6'b000010) || (op == 6'b000011) ||
               (op[5:2] == 4'b0001) ||
               ((op == 6'b000000) && ((fn == 6'b001000) || (fn == 6'b001001)));
    endfunction

    logic              slot_valid_q, slot_valid_d;
    logic [31:0]       slot_pc_q, slot_pc_d;
    logic [31:0]       slot_instr_q, slot_instr_d;
    logic              ds_flag_q, ds_flag_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

`ifdef DECODE_ISSUE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [31:0]       skid_pc_q, skid_pc_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
`endif

    logic [DATA_W:0]   rs_res;
    logic [DATA_W:0]   rt_res;
    logic              hazard;
    logic              fire;
    logic              accept;

    assign rf_rs_addr = REG_ADDR_W'(slot_instr_q[25:21]);
    assign rf_rt_addr = REG_ADDR_W'(slot_instr_q[20:16]);

    always_comb begin
        rs_res = resolve(rf_rs_addr, rf_rs_data, fwd_valid, fwd_rd, fwd_data_ok, fwd_data);
        rt_res = resolve(rf_rt_addr, rf_rt_data, fwd_valid, fwd_rd, fwd_data_ok, fwd_data);
    end

    assign hazard    = slot_valid_q && (rs_res[DATA_W] || rt_res[DATA_W]);
    assign out_valid = slot_valid_q && !hazard && !flush;
    assign fire      = out_valid && out_ready;

`ifdef DECODE_ISSUE_SKID_EN
    // Registered-only ready: no combinational path from out_ready.
    assign in_ready = !skid_valid_q && !flush;
`else
    assign in_ready = !flush && (!slot_valid_q || fire);
`endif

    assign accept = in_valid && in_ready;

    assign out_pc         = slot_pc_q;
    assign out_instr      = slot_instr_q;
    assign out_vs         = slot_valid_q ? rs_res[DATA_W-1:0] : '0;
    assign out_vt         = slot_valid_q ? rt_res[DATA_W-1:0] : '0;
    assign out_delay_slot = ds_flag_q;
    assign stall_count    = stall_q;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
`ifdef DECODE_ISSUE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            slot_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid only fills while the slot is held, so it drains on the next fire.
            if (fire) begin
                slot_pc_d    = skid_pc_q;
                slot_instr_d = skid_instr_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!slot_valid_q || fire) begin
                slot_valid_d = 1'b1;
                slot_pc_d    = in_pc;
                slot_instr_d = in_instr;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = in_pc;
                skid_instr_d = in_instr;
            end
        end else if (fire) begin
            slot_valid_d = 1'b0;
        end
`else
        if (flush) begin
            slot_valid_d = 1'b0;
        end else if (accept) begin
            slot_valid_d = 1'b1;
            slot_pc_d    = in_pc;
            slot_instr_d = in_instr;
        end else if (fire) begin
            slot_valid_d = 1'b0;
        end
`endif
    end

    always_comb begin
        ds_flag_d = ds_flag_q;
        if (flush) begin
            ds_flag_d = 1'b0;
        end else if (fire) begin
            ds_flag_d = is_branch(slot_instr_q);
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (hazard && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_instr_q <= '0;
            ds_flag_q    <= 1'b0;
            stall_q      <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
            ds_flag_q    <= ds_flag_d;
            stall_q      <= stall_d;
        end
    end

`ifdef DECODE_ISSUE_SKID_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage (default single-slot or skid build).
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [4:0]  rf_rs_addr;
    logic [4:0]  rf_rt_addr;
    logic [31:0] rf_rs_data;
    logic [31:0] rf_rt_data;
    logic [2:0]  fwd_valid;
    logic [14:0] fwd_rd;
    logic [2:0]  fwd_data_ok;
    logic [95:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_vs;
    logic [31:0] out_vt;
    logic        out_delay_slot;
    logic [31:0] stall_count;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] ADDU_R8  = 32'h0100_5021; // addu r10, r8, r0
    localparam logic [31:0] ADDU_R9  = 32'h0009_5021; // addu r10, r0, r9
    localparam logic [31:0] BEQ_8_9  = 32'h1109_0004; // beq r8, r9, +4

    decode_issue_stage #(
        .FWD_STAGES (3),
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .CNT_W      (32)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .rf_rs_addr     (rf_rs_addr),
        .rf_rt_addr     (rf_rt_addr),
        .rf_rs_data     (rf_rs_data),
        .rf_rt_data     (rf_rt_data),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data_ok    (fwd_data_ok),
        .fwd_data       (fwd_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_vs         (out_vs),
        .out_vt         (out_vt),
        .out_delay_slot (out_delay_slot),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_fwd();
        fwd_valid   = '0;
        fwd_rd      = '0;
        fwd_data_ok = '0;
        fwd_data    = '0;
    endtask

    // Loads one instruction into an empty stage while downstream is stalled.
    task automatic load(input logic [31:0] pc, input logic [31:0] instr);
        in_valid  = 1'b1;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_ready pc=%h: got %b expected 1", pc, in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input logic exp_ds);
        load(pc, instr);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== pc) begin
            failures++;
            $display("FAIL issue_offer pc=%h: got valid=%b pc=%h expected valid=1 pc=%h",
                     pc, out_valid, out_pc, pc);
        end
        checks++;
        if (out_delay_slot !== exp_ds) begin
            failures++;
            $display("FAIL issue_delay_slot pc=%h: got %b expected %b", pc, out_delay_slot, exp_ds);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got valid=%b ready=%b stall=%0d expected 0 1 0",
                     out_valid, in_ready, stall_count);
        end
        checks++;
        if (out_pc !== 32'd0 || out_instr !== 32'd0 || out_vs !== 32'd0 || out_vt !== 32'd0
            || out_delay_slot !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: got pc=%h instr=%h vs=%h vt=%h ds=%b expected all 0",
                     out_pc, out_instr, out_vs, out_vt, out_delay_slot);
        end
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_fire cycle=%0d: got valid=%b expected 0", c, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_forward_priority();
        rf_rs_data = 32'h99;
        load(32'h0000_0010, ADDU_R8);
        fwd_valid            = 3'b101;
        fwd_rd[0 +: 5]       = 5'd8;
        fwd_rd[10 +: 5]      = 5'd8;
        fwd_data_ok          = 3'b111;
        fwd_data[0 +: 32]    = 32'h11;
        fwd_data[64 +: 32]   = 32'h33;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_vs !== 32'h11) begin
            failures++;
            $display("FAIL fwd_youngest: got valid=%b vs=%h expected 1 00000011", out_valid, out_vs);
        end
        fwd_valid = 3'b100;
        #1;
        checks++;
        if (out_vs !== 32'h33) begin
            failures++;
            $display("FAIL fwd_oldest: got vs=%h expected 00000033", out_vs);
        end
        fwd_valid = 3'b000;
        #1;
        checks++;
        if (out_vs !== 32'h99 || out_vt !== 32'h0) begin
            failures++;
            $display("FAIL fwd_rf_fallback: got vs=%h vt=%h expected 00000099 0", out_vs, out_vt);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        clear_fwd();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fwd_drained: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_load_use();
        load(32'h0000_0020, ADDU_R9);
        fwd_valid      = 3'b001;
        fwd_rd[0 +: 5] = 5'd9;
        fwd_data_ok    = 3'b000;
        out_ready      = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL lu_interlock cycle=%0d: got valid=%b expected 0", c, out_valid);
            end
            tick();
        end
        fwd_data_ok       = 3'b001;
        fwd_data[0 +: 32] = 32'hCAFE;
        #1;
        checks++;
        if (stall_count !== 32'd2) begin
            failures++;
            $display("FAIL lu_stall_count: got %0d expected 2", stall_count);
        end
        checks++;
        if (out_valid !== 1'b1 || out_vt !== 32'hCAFE || out_vs !== 32'h0) begin
            failures++;
            $display("FAIL lu_release: got valid=%b vt=%h vs=%h expected 1 0000cafe 0",
                     out_valid, out_vt, out_vs);
        end
        tick();
        out_ready = 1'b0;
        clear_fwd();
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall_count !== 32'd2) begin
            failures++;
            $display("FAIL lu_after_fire: got valid=%b stall=%0d expected 0 2",
                     out_valid, stall_count);
        end
    endtask

    task automatic test_delay_slot();
        issue(32'h0000_0100, BEQ_8_9, 1'b0);
        issue(32'h0000_0104, ADDU_R8, 1'b1);
        issue(32'h0000_0108, ADDU_R8, 1'b0);
    endtask

    task automatic test_flush();
        issue(32'h0000_0200, BEQ_8_9, 1'b0);
        load(32'h0000_0204, ADDU_R8);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h0000_0300;
        in_instr  = 32'h0000_1021;
        flush     = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_gate: got valid=%b ready=%b expected 0 0", out_valid, in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_delay_slot !== 1'b0 || stall_count !== 32'd2) begin
            failures++;
            $display("FAIL flush_after: got valid=%b ds=%b stall=%0d expected 0 0 2",
                     out_valid, out_delay_slot, stall_count);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_dropped cycle=%0d: got valid=%b pc=%h expected 0",
                         c, out_valid, out_pc);
            end
        end
        out_ready = 1'b0;
        issue(32'h0000_0208, ADDU_R8, 1'b0);
    endtask

    task automatic test_ready_path();
        logic r0;
        load(32'h0000_0400, ADDU_R8);
`ifdef DECODE_ISSUE_SKID_EN
        r0 = in_ready;
        out_ready = 1'b1;
        #1;
        checks++;
        if (r0 !== 1'b1 || in_ready !== r0) begin
            failures++;
            $display("FAIL skid_ready_indep: got %b/%b expected 1/1", r0, in_ready);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h0000_0404;
        in_instr  = ADDU_R9;
        tick();
        in_valid = 1'b0;
        #1;
        r0 = in_ready;
        out_ready = 1'b1;
        #1;
        checks++;
        if (r0 !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL skid_full_ready: got %b/%b expected 0/0", r0, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0000_0404) begin
            failures++;
            $display("FAIL skid_drain: got valid=%b pc=%h expected 1 00000404", out_valid, out_pc);
        end
        tick();
`else
        r0 = in_ready;
        out_ready = 1'b1;
        #1;
        checks++;
        if (r0 !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_through_fire: got %b/%b expected 0/1", r0, in_ready);
        end
        tick();
`endif
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ready_path_empty: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        int issued;
        int cyc;
        sent   = 0;
        issued = 0;
        cyc    = 0;
        while (issued < 8 && cyc < 100) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (sent < 8);
            in_pc     = 32'h0000_1000 + 32'(sent * 4);
            in_instr  = 32'h0000_0021 | 32'(sent << 11);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_pc !== 32'h0000_1000 + 32'(issued * 4)
                    || out_instr !== (32'h0000_0021 | 32'(issued << 11))) begin
                    failures++;
                    $display("FAIL b2b_order idx=%0d: got pc=%h instr=%h expected pc=%h",
                             issued, out_pc, out_instr, 32'h0000_1000 + 32'(issued * 4));
                end
                issued++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (issued != 8) begin
            failures++;
            $display("FAIL b2b_count: got %0d expected 8", issued);
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_empty: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        load(32'h0000_0500, ADDU_R9);
        fwd_valid      = 3'b010;
        fwd_rd[5 +: 5] = 5'd9;
        fwd_data_ok    = 3'b000;
        out_ready      = 1'b1;
        tick();
        #1;
        checks++;
        if (stall_count !== 32'd3 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_stall: got stall=%0d valid=%b expected 3 0", stall_count, out_valid);
        end
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (stall_count !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: got stall=%0d valid=%b ready=%b expected 0 0 1",
                     stall_count, out_valid, in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        clear_fwd();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_discard cycle=%0d: got valid=%b expected 0", c, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_pc      = '0;
        in_instr   = '0;
        out_ready  = 1'b0;
        rf_rs_data = 32'h99;
        rf_rt_data = 32'h77;
        clear_fwd();
        test_reset();
        test_forward_priority();
        test_load_use();
        test_delay_slot();
        test_flush();
        test_ready_path();
        test_back_to_back();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
